// File: rtl/rate_ctrl_if.sv
// Control, period-load and status signals of rate_ctrl, bundled for the port list.
// load_valid/load_ready: a period transfers on a rising edge where both are high; the offer may be held or withdrawn freely.
interface rate_ctrl_if #(
  parameter int N = 26
);
  logic         start;
  logic         stop;
  logic         oneshot;
  logic         load_valid;
  logic [N-1:0] load_val;
  logic         load_ready;
  logic         tick;
  logic         q;
  logic         busy;
  logic [7:0]   tick_cnt;
  logic [1:0]   state_dbg;

  modport master (
    output start, stop, oneshot, load_valid, load_val,
    input  load_ready, tick, q, busy, tick_cnt, state_dbg
  );

  modport slave (
    input  start, stop, oneshot, load_valid, load_val,
    output load_ready, tick, q, busy, tick_cnt, state_dbg
  );
endinterface

// File: rtl/rate_ctrl.sv
// Programmable-period tick generator with pause/resume and a square-wave output.
// Optional single-tick mode is compiled in when RATE_CTRL_ONESHOT_EN is defined.
module rate_ctrl #(
  parameter int          N     = 26,
  parameter int unsigned M_DEF = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  rate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] count, count_n;
  logic [N-1:0] period, period_n;
  logic [7:0]   tick_cnt, tick_cnt_n;
  logic         tick, tick_n;
  logic         os_mode, os_mode_n;
  logic         load_fire;
  logic         wrap;

  assign load_fire = bus.load_valid && (state == IDLE);
  assign wrap      = (count == period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      period   <= N'(M_DEF);
      tick     <= 1'b0;
      tick_cnt <= 8'd0;
      os_mode  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      period   <= period_n;
      tick     <= tick_n;
      tick_cnt <= tick_cnt_n;
      os_mode  <= os_mode_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = count;
    period_n   = period;
    tick_n     = 1'b0;
    tick_cnt_n = tick_cnt;
    os_mode_n  = os_mode;
    case (state)
      IDLE: begin
        // A zero period would never let count leave 0 meaningfully; clamp to 1.
        if (load_fire) period_n = (bus.load_val == '0) ? N'(1) : bus.load_val;
        if (bus.start) begin
          state_n    = RUN;
          count_n    = '0;
          tick_cnt_n = 8'd0;
`ifdef RATE_CTRL_ONESHOT_EN
          os_mode_n  = bus.oneshot;
`else
          os_mode_n  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = HOLD;
        end else if (wrap) begin
          count_n    = '0;
          tick_n     = 1'b1;
          tick_cnt_n = tick_cnt + 8'd1;
`ifdef RATE_CTRL_ONESHOT_EN
          if (os_mode) state_n = IDLE;
`endif
        end else begin
          count_n = count + N'(1);
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_n = IDLE;
          count_n = '0;
        end else if (bus.start) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

`ifndef RATE_CTRL_ONESHOT_EN
  logic unused_oneshot;
  assign unused_oneshot = bus.oneshot ^ os_mode;
`endif

  assign bus.busy       = (state != IDLE);
  assign bus.load_ready = (state == IDLE);
  assign bus.q          = (state != IDLE) && (count >= (period >> 1));
  assign bus.tick       = tick;
  assign bus.tick_cnt   = tick_cnt;
  assign bus.state_dbg  = state;

endmodule
